// File: rtl/syn_sram_arb_if.sv
// Bundle of the VGA, GPU and SRAM-driver handshake signals around the VCORTEX SRAM arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding requesters and driver.
interface syn_sram_arb_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_ack;
    logic              vga_rd_valid;
    logic [DATA_W-1:0] vga_rd_data;

    logic              gpu_req;
    logic              gpu_we;
    logic [ADDR_W-1:0] gpu_addr;
    logic [DATA_W-1:0] gpu_wr_data;
    logic              gpu_ack;
    logic              gpu_rd_valid;
    logic [DATA_W-1:0] gpu_rd_data;

    logic              sram_req;
    logic              sram_we;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wr_data;
    logic              sram_ready;
    logic              sram_rd_valid;
    logic [DATA_W-1:0] sram_rd_data;

    logic              arb_err;

    modport slave (
        input  vga_req, vga_addr,
        output vga_ack, vga_rd_valid, vga_rd_data,
        input  gpu_req, gpu_we, gpu_addr, gpu_wr_data,
        output gpu_ack, gpu_rd_valid, gpu_rd_data,
        output sram_req, sram_we, sram_addr, sram_wr_data,
        input  sram_ready, sram_rd_valid, sram_rd_data,
        output arb_err
    );

    modport master (
        output vga_req, vga_addr,
        input  vga_ack, vga_rd_valid, vga_rd_data,
        output gpu_req, gpu_we, gpu_addr, gpu_wr_data,
        input  gpu_ack, gpu_rd_valid, gpu_rd_data,
        input  sram_req, sram_we, sram_addr, sram_wr_data,
        output sram_ready, sram_rd_valid, sram_rd_data,
        input  arb_err
    );
endinterface

// File: rtl/syn_sram_arb.sv
// SRAM port arbiter between the real-time VGA reader and the GPU, with a bounded VGA burst
// and a tag FIFO that steers in-order read returns back to whoever issued them.
module syn_sram_arb #(
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 16,
    parameter int VGA_MAX_BURST = 8,
    parameter int TAG_DEPTH     = 4
) (
    input  logic           clk_ir,
    input  logic           rst_sync_l,
    syn_sram_arb_if.slave  bus
);
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH + 1);
    localparam logic [CNT_W-1:0] TAG_FULL  = CNT_W'(TAG_DEPTH);
    localparam logic [7:0]       BURST_MAX = 8'(VGA_MAX_BURST);

    typedef enum logic [0:0] {
        PRIO_VGA = 1'b0,
        PRIO_GPU = 1'b1
    } arb_state_t;

    arb_state_t        state_r, state_nxt_s;
    logic [7:0]        burst_r, burst_nxt_s;
    logic              slot_free_s, tag_room_s;
    logic              vga_elig_s, gpu_elig_s;
    logic              vga_grant_s, gpu_grant_s;
    logic              push_s, pop_s, tag_empty_s, head_tag_s;
    logic              tag_mem_r [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]  tag_cnt_r;
    logic              sram_req_r, sram_we_r;
    logic [ADDR_W-1:0] sram_addr_r;
    logic [DATA_W-1:0] sram_wr_data_r;
    logic              arb_err_r;

    // Eligibility: a free output slot, plus tag room for reads; nothing is eligible in reset.
    always_comb begin
        slot_free_s = !sram_req_r || bus.sram_ready;
        tag_room_s  = (tag_cnt_r < TAG_FULL);
        vga_elig_s  = rst_sync_l && bus.vga_req && slot_free_s && tag_room_s;
        gpu_elig_s  = rst_sync_l && bus.gpu_req && slot_free_s && (bus.gpu_we || tag_room_s);
    end

    // Priority FSM next state, burst accounting and grant selection.
    always_comb begin
        state_nxt_s = state_r;
        burst_nxt_s = burst_r;
        vga_grant_s = 1'b0;
        gpu_grant_s = 1'b0;
        case (state_r)
            PRIO_VGA: begin
                if (vga_elig_s) begin
                    vga_grant_s = 1'b1;
                end else if (gpu_elig_s) begin
                    gpu_grant_s = 1'b1;
                end else begin
                    vga_grant_s = 1'b0;
                    gpu_grant_s = 1'b0;
                end
                // Only VGA grants that make the GPU wait count towards the burst limit.
                if (!bus.gpu_req) begin
                    burst_nxt_s = 8'd0;
                end else if (vga_grant_s && (burst_r < BURST_MAX)) begin
                    burst_nxt_s = burst_r + 8'd1;
                end else begin
                    burst_nxt_s = burst_r;
                end
                if (burst_nxt_s >= BURST_MAX) begin
                    state_nxt_s = PRIO_GPU;
                end else begin
                    state_nxt_s = PRIO_VGA;
                end
            end
            PRIO_GPU: begin
                if (!bus.gpu_req) begin
                    burst_nxt_s = 8'd0;
                    state_nxt_s = PRIO_VGA;
                end else if (gpu_elig_s) begin
                    gpu_grant_s = 1'b1;
                    burst_nxt_s = 8'd0;
                    state_nxt_s = PRIO_VGA;
                end else begin
                    state_nxt_s = PRIO_GPU;
                end
            end
            default: begin
                state_nxt_s = PRIO_VGA;
                burst_nxt_s = 8'd0;
            end
        endcase
    end

    // FSM state and burst counter registers.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            state_r <= PRIO_VGA;
            burst_r <= 8'd0;
        end else begin
            state_r <= state_nxt_s;
            burst_r <= burst_nxt_s;
        end
    end

    // Registered request stage towards the SRAM driver; held while the driver stalls.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            sram_req_r     <= 1'b0;
            sram_we_r      <= 1'b0;
            sram_addr_r    <= '0;
            sram_wr_data_r <= '0;
        end else if (vga_grant_s) begin
            sram_req_r     <= 1'b1;
            sram_we_r      <= 1'b0;
            sram_addr_r    <= bus.vga_addr;
            sram_wr_data_r <= '0;
        end else if (gpu_grant_s) begin
            sram_req_r     <= 1'b1;
            sram_we_r      <= bus.gpu_we;
            sram_addr_r    <= bus.gpu_addr;
            sram_wr_data_r <= bus.gpu_wr_data;
        end else if (bus.sram_ready) begin
            sram_req_r     <= 1'b0;
        end else begin
            sram_req_r     <= sram_req_r;
        end
    end

    assign push_s      = vga_grant_s || (gpu_grant_s && !bus.gpu_we);
    assign tag_empty_s = (tag_cnt_r == '0);
    assign head_tag_s  = tag_mem_r[rd_ptr_r];
    assign pop_s       = bus.sram_rd_valid && !tag_empty_s;

    // Tag FIFO: 0 marks a VGA read, 1 a GPU read; pointers wrap at the power-of-two depth.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            for (int i = 0; i < TAG_DEPTH; i++) begin
                tag_mem_r[i] <= 1'b0;
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            tag_cnt_r <= '0;
        end else begin
            if (push_s) begin
                tag_mem_r[wr_ptr_r] <= gpu_grant_s;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   tag_cnt_r <= tag_cnt_r + CNT_W'(1);
                2'b01:   tag_cnt_r <= tag_cnt_r - CNT_W'(1);
                default: tag_cnt_r <= tag_cnt_r;
            endcase
        end
    end

    // Sticky error on a read return that has no outstanding tag.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            arb_err_r <= 1'b0;
        end else if (bus.sram_rd_valid && tag_empty_s) begin
            arb_err_r <= 1'b1;
        end else begin
            arb_err_r <= arb_err_r;
        end
    end

    assign bus.vga_ack      = vga_grant_s;
    assign bus.gpu_ack      = gpu_grant_s;
    assign bus.vga_rd_valid = pop_s && !head_tag_s;
    assign bus.gpu_rd_valid = pop_s && head_tag_s;
    assign bus.vga_rd_data  = bus.sram_rd_data;
    assign bus.gpu_rd_data  = bus.sram_rd_data;
    assign bus.sram_req     = sram_req_r;
    assign bus.sram_we      = sram_we_r;
    assign bus.sram_addr    = sram_addr_r;
    assign bus.sram_wr_data = sram_wr_data_r;
    assign bus.arb_err      = arb_err_r;
endmodule

// File: tb/tb_syn_sram_arb.sv
// Directed bench for syn_sram_arb: burst bound, backpressure, tag full, return routing, error, reset.
// A latency-2 driver model can return read data, or the sequence drives returns by hand.
module tb_syn_sram_arb;
    localparam int ADDR_W = 18;
    localparam int DATA_W = 16;

    logic        clk_ir     = 1'b0;
    logic        rst_sync_l = 1'b0;
    int          tests_run    = 0;
    int          tests_failed = 0;
    logic        auto_ret;
    logic        man_valid;
    logic [15:0] man_data;
    logic        p1_valid, p2_valid;
    logic [15:0] p1_data, p2_data;
    logic [15:0] rdat [3];

    syn_sram_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    syn_sram_arb #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .VGA_MAX_BURST(8), .TAG_DEPTH(4)
    ) dut (
        .clk_ir(clk_ir),
        .rst_sync_l(rst_sync_l),
        .bus(bus)
    );

    always #5 clk_ir = ~clk_ir;

    // Driver model: an accepted read returns its low address bits two cycles later.
    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            p1_valid <= 1'b0;
            p1_data  <= 16'h0000;
            p2_valid <= 1'b0;
            p2_data  <= 16'h0000;
        end else begin
            p1_valid <= bus.sram_req && bus.sram_ready && !bus.sram_we;
            p1_data  <= bus.sram_addr[15:0];
            p2_valid <= p1_valid;
            p2_data  <= p1_data;
        end
    end

    assign bus.sram_rd_valid = auto_ret ? p2_valid : man_valid;
    assign bus.sram_rd_data  = auto_ret ? p2_data  : man_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_ir);
        #1;
    endtask

    initial begin
        rdat[0] = 16'h1111;
        rdat[1] = 16'h2222;
        rdat[2] = 16'h3333;
        auto_ret        = 1'b1;
        man_valid       = 1'b0;
        man_data        = 16'h0000;
        bus.vga_req     = 1'b0;
        bus.vga_addr    = 18'h00000;
        bus.gpu_req     = 1'b0;
        bus.gpu_we      = 1'b0;
        bus.gpu_addr    = 18'h00000;
        bus.gpu_wr_data = 16'h0000;
        bus.sram_ready  = 1'b1;

        // Reset state
        #12;
        check("rst_sram_req", 32'(bus.sram_req), 32'd0);
        check("rst_vga_ack", 32'(bus.vga_ack), 32'd0);
        check("rst_gpu_ack", 32'(bus.gpu_ack), 32'd0);
        check("rst_vga_rd_valid", 32'(bus.vga_rd_valid), 32'd0);
        check("rst_gpu_rd_valid", 32'(bus.gpu_rd_valid), 32'd0);
        check("rst_arb_err", 32'(bus.arb_err), 32'd0);
        check("rst_sram_addr", 32'(bus.sram_addr), 32'd0);
        tick;
        rst_sync_l = 1'b1;

        // VGA only: 4 back-to-back reads, returns after 2 cycles
        for (int i = 0; i < 8; i++) begin
            bus.vga_req  = (i < 4);
            bus.vga_addr = 18'h00100 + 18'(i);
            #4;
            check("t1_vga_ack", 32'(bus.vga_ack), 32'(i < 4));
            check("t1_sram_req", 32'(bus.sram_req), 32'(i >= 1 && i <= 4));
            if (i >= 1 && i <= 4) check("t1_sram_addr", 32'(bus.sram_addr), 32'h100 + 32'(i) - 32'd1);
            check("t1_vga_rd_valid", 32'(bus.vga_rd_valid), 32'(i >= 3 && i <= 6));
            check("t1_gpu_rd_valid", 32'(bus.gpu_rd_valid), 32'd0);
            if (i >= 3 && i <= 6) check("t1_vga_rd_data", 32'(bus.vga_rd_data), 32'h100 + 32'(i) - 32'd3);
            tick;
        end

        // Starvation guard: 8 VGA acks, one GPU write, then VGA again
        bus.vga_req     = 1'b1;
        bus.vga_addr    = 18'h00200;
        bus.gpu_req     = 1'b1;
        bus.gpu_we      = 1'b1;
        bus.gpu_addr    = 18'h3FFFF;
        bus.gpu_wr_data = 16'hA5A5;
        for (int i = 0; i < 10; i++) begin
            #4;
            check("t2_vga_ack", 32'(bus.vga_ack), 32'(i != 8));
            check("t2_gpu_ack", 32'(bus.gpu_ack), 32'(i == 8));
            if (i >= 1) check("t2_sram_we", 32'(bus.sram_we), 32'(i == 9));
            if (i == 9) begin
                check("t2_sram_addr", 32'(bus.sram_addr), 32'h3FFFF);
                check("t2_sram_wr_data", 32'(bus.sram_wr_data), 32'hA5A5);
            end
            tick;
        end
        bus.vga_req = 1'b0;
        bus.gpu_req = 1'b0;
        bus.gpu_we  = 1'b0;
        repeat (5) tick;
        #4;
        check("t2_idle_sram_req", 32'(bus.sram_req), 32'd0);
        tick;

        // Backpressure: driver stalls for 3 cycles after the first GPU read
        bus.gpu_req  = 1'b1;
        bus.gpu_addr = 18'h00ABC;
        #4;
        check("t3_gpu_ack0", 32'(bus.gpu_ack), 32'd1);
        tick;
        bus.gpu_addr   = 18'h00ABD;
        bus.sram_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #4;
            check("t3_stall_ack", 32'(bus.gpu_ack), 32'd0);
            check("t3_stall_req", 32'(bus.sram_req), 32'd1);
            check("t3_stall_addr", 32'(bus.sram_addr), 32'h00ABC);
            tick;
        end
        bus.sram_ready = 1'b1;
        #4;
        check("t3_resume_ack", 32'(bus.gpu_ack), 32'd1);
        check("t3_resume_addr", 32'(bus.sram_addr), 32'h00ABC);
        tick;
        bus.gpu_req = 1'b0;
        #4;
        check("t3_next_addr", 32'(bus.sram_addr), 32'h00ABD);
        tick;
        #4;
        check("t3_rd_valid0", 32'(bus.gpu_rd_valid), 32'd1);
        check("t3_rd_data0", 32'(bus.gpu_rd_data), 32'h0ABC);
        tick;
        #4;
        check("t3_rd_valid1", 32'(bus.gpu_rd_valid), 32'd1);
        check("t3_rd_data1", 32'(bus.gpu_rd_data), 32'h0ABD);
        tick;

        // Tag full: 4 outstanding GPU reads block a 5th read but not a write
        auto_ret = 1'b0;
        repeat (2) tick;
        for (int i = 0; i < 4; i++) begin
            bus.gpu_req  = 1'b1;
            bus.gpu_we   = 1'b0;
            bus.gpu_addr = 18'h00010 + 18'(i);
            #4;
            check("t4_fill_ack", 32'(bus.gpu_ack), 32'd1);
            tick;
        end
        bus.gpu_addr = 18'h00014;
        #4;
        check("t4_full_ack", 32'(bus.gpu_ack), 32'd0);
        tick;
        bus.gpu_we      = 1'b1;
        bus.gpu_addr    = 18'h00020;
        bus.gpu_wr_data = 16'h1234;
        #4;
        check("t4_write_ack", 32'(bus.gpu_ack), 32'd1);
        tick;
        bus.gpu_we   = 1'b0;
        bus.gpu_addr = 18'h00014;
        man_valid    = 1'b1;
        man_data     = 16'h5555;
        #4;
        check("t4_pop_cycle_ack", 32'(bus.gpu_ack), 32'd0);
        check("t4_pop_valid", 32'(bus.gpu_rd_valid), 32'd1);
        check("t4_pop_data", 32'(bus.gpu_rd_data), 32'h5555);
        tick;
        man_valid = 1'b0;
        #4;
        check("t4_after_pop_ack", 32'(bus.gpu_ack), 32'd1);
        tick;
        bus.gpu_req = 1'b0;
        for (int j = 0; j < 4; j++) begin
            man_valid = 1'b1;
            man_data  = 16'h6000 + 16'(j);
            #4;
            check("t4_drain_gpu", 32'(bus.gpu_rd_valid), 32'd1);
            check("t4_drain_vga", 32'(bus.vga_rd_valid), 32'd0);
            tick;
        end
        man_valid = 1'b0;

        // Mixed routing: VGA, GPU, VGA reads come back to their owners in order
        bus.vga_req  = 1'b1;
        bus.vga_addr = 18'h00040;
        #4;
        check("t5_vga_ack0", 32'(bus.vga_ack), 32'd1);
        tick;
        bus.vga_req  = 1'b0;
        bus.gpu_req  = 1'b1;
        bus.gpu_addr = 18'h00041;
        #4;
        check("t5_gpu_ack", 32'(bus.gpu_ack), 32'd1);
        tick;
        bus.gpu_req  = 1'b0;
        bus.vga_req  = 1'b1;
        bus.vga_addr = 18'h00042;
        #4;
        check("t5_vga_ack1", 32'(bus.vga_ack), 32'd1);
        tick;
        bus.vga_req = 1'b0;
        tick;
        for (int j = 0; j < 3; j++) begin
            man_valid = 1'b1;
            man_data  = rdat[j];
            #4;
            check("t5_vga_valid", 32'(bus.vga_rd_valid), 32'(j != 1));
            check("t5_gpu_valid", 32'(bus.gpu_rd_valid), 32'(j == 1));
            if (j == 1) check("t5_gpu_data", 32'(bus.gpu_rd_data), 32'(rdat[j]));
            else        check("t5_vga_data", 32'(bus.vga_rd_data), 32'(rdat[j]));
            tick;
        end
        man_valid = 1'b0;

        // Spurious return sets the sticky error
        man_valid = 1'b1;
        man_data  = 16'hDEAD;
        #4;
        check("t6_spur_vga", 32'(bus.vga_rd_valid), 32'd0);
        check("t6_spur_gpu", 32'(bus.gpu_rd_valid), 32'd0);
        check("t6_err_before", 32'(bus.arb_err), 32'd0);
        tick;
        man_valid = 1'b0;
        #4;
        check("t6_err_set", 32'(bus.arb_err), 32'd1);
        tick;

        // Reset mid-burst, then VGA priority after release
        auto_ret        = 1'b1;
        bus.vga_req     = 1'b1;
        bus.vga_addr    = 18'h00080;
        bus.gpu_req     = 1'b1;
        bus.gpu_we      = 1'b1;
        bus.gpu_addr    = 18'h3FFFF;
        repeat (3) tick;
        #2;
        rst_sync_l = 1'b0;
        #1;
        check("t7_rst_sram_req", 32'(bus.sram_req), 32'd0);
        check("t7_rst_err", 32'(bus.arb_err), 32'd0);
        check("t7_rst_vga_ack", 32'(bus.vga_ack), 32'd0);
        check("t7_rst_gpu_ack", 32'(bus.gpu_ack), 32'd0);
        tick;
        rst_sync_l = 1'b1;
        #4;
        check("t7_post_vga_ack", 32'(bus.vga_ack), 32'd1);
        check("t7_post_gpu_ack", 32'(bus.gpu_ack), 32'd0);
        check("t7_post_sram_req", 32'(bus.sram_req), 32'd0);
        tick;
        #4;
        check("t7_post_issue", 32'(bus.sram_req), 32'd1);
        bus.vga_req = 1'b0;
        bus.gpu_req = 1'b0;
        repeat (4) tick;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/syn_sram_arb.md
Name: syn_sram_arb

Overview:
- Arbitrates the single SRAM driver port between two requesters inside VCORTEX.
- Requesters are the VGA driver (read-only, real-time, high priority) and the GPU (read/write).
- Issues one transaction per cycle to the SRAM driver through a registered request stage.
- Routes in-order read returns back to the originating requester through a tag FIFO.
- Bounds VGA bursts so the GPU is never starved.

Parameters:
- ADDR_W, 18, SRAM word address width.
- DATA_W, 16, SRAM data width.
- VGA_MAX_BURST, 8, maximum consecutive VGA grants while the GPU is waiting (range 1-255).
- TAG_DEPTH, 4, number of outstanding reads tracked (power of 2).

Ports:
- clk_ir  in  1  system clock
- rst_sync_l  in  1  reset, asynchronous, active-low
- vga_req  in  1  VGA read request, held until acked
- vga_addr  in  ADDR_W  VGA read address
- vga_ack  out  1  VGA request accepted this cycle
- vga_rd_valid  out  1  VGA read data valid
- vga_rd_data  out  DATA_W  VGA read data
- gpu_req  in  1  GPU request, held until acked
- gpu_we  in  1  1 = write, 0 = read
- gpu_addr  in  ADDR_W  GPU address
- gpu_wr_data  in  DATA_W  GPU write data
- gpu_ack  out  1  GPU request accepted this cycle
- gpu_rd_valid  out  1  GPU read data valid
- gpu_rd_data  out  DATA_W  GPU read data
- sram_req  out  1  request to the SRAM driver
- sram_we  out  1  write qualifier
- sram_addr  out  ADDR_W  address
- sram_wr_data  out  DATA_W  write data
- sram_ready  in  1  driver accepts sram_req this cycle
- sram_rd_valid  in  1  driver read return, in issue order
- sram_rd_data  in  DATA_W  driver read data
- arb_err  out  1  sticky: read return with no outstanding tag

Behaviour:
- Reset: all outputs 0. Tag FIFO empty, burst counter 0, state PRIO_VGA. All registers are asynchronously cleared on rst_sync_l low; in-flight requests and tags are discarded.
- Slot free: slot_free = !sram_req | sram_ready.
- Grant: occurs only when slot_free.
  - A read grant additionally requires tag count < TAG_DEPTH, evaluated from the registered count; a same-cycle pop does not free a slot.
  - GPU writes ignore the tag FIFO.
- Acks: vga_ack and gpu_ack are combinational, mutually exclusive, one-cycle pulses.
  - An acked request's fields are captured into sram_* at the next clock edge; sram_req rises one cycle after the ack.
  - With sram_ready held high, back-to-back grants sustain one transaction per cycle.
- Output stage hold: sram_req/we/addr/wr_data are held stable while sram_req=1 and sram_ready=0. sram_req drops to 0 after an accepted transfer if nothing is granted that cycle.
- FSM, state PRIO_VGA:
  - VGA wins whenever eligible; otherwise GPU wins.
  - Each VGA grant while gpu_req=1 increments burst_cnt.
  - When burst_cnt reaches VGA_MAX_BURST, go to PRIO_GPU.
  - gpu_req=0 clears burst_cnt.
- FSM, state PRIO_GPU:
  - GPU wins if eligible.
  - On a GPU grant, clear burst_cnt and return to PRIO_VGA.
  - If gpu_req drops, return to PRIO_VGA without a grant.
  - If the GPU request is an ineligible read (tags full), nobody is granted.
- Tags:
  - Push on every read grant: 0 = VGA, 1 = GPU.
  - Pop on sram_rd_valid. Pop-head 0 drives vga_rd_valid; pop-head 1 drives gpu_rd_valid, both combinational from sram_rd_valid.
  - Both rd_data outputs mirror sram_rd_data.
  - Simultaneous push and pop leaves the count unchanged.
- Error: sram_rd_valid with an empty FIFO gives no rd_valid output and sets arb_err. arb_err is cleared only by reset.
- Wrap-around: FIFO pointers wrap modulo TAG_DEPTH; burst_cnt saturates at VGA_MAX_BURST.

Test Plan:
- VGA only, sram_ready=1, vga_req held for 4 cycles with addresses 0x100-0x103:
  - 4 consecutive vga_acks; sram_req high for 4 cycles, offset +1.
  - With driver read latency 2, vga_rd_valid returns 4 data words in order; gpu_rd_valid stays 0.
- Starvation guard: vga_req and gpu_req (write, addr 0x3FFFF, data 0xA5A5) held continuously, VGA_MAX_BURST=8:
  - Exactly 8 vga_acks, then 1 gpu_ack, then VGA resumes; sram_we=1 on the 9th issued transfer.
- Backpressure: sram_ready=0 for 3 cycles after the first GPU read:
  - sram_addr held constant; no further acks until sram_ready=1.
- Tag full: 4 GPU reads issued with no returns, TAG_DEPTH=4:
  - 5th read not acked; a GPU write is still acked.
  - One sram_rd_valid pops the FIFO, and the 5th read is acked the following cycle.
- Mixed return routing: issue VGA, GPU, VGA reads, then return data 0x1111, 0x2222, 0x3333:
  - vga_rd_valid, gpu_rd_valid, vga_rd_valid, each carrying the matching data.
- Spurious return and reset:
  - sram_rd_valid with an empty FIFO sets arb_err=1.
  - Reset asserted mid-burst clears sram_req, arb_err and the acks asynchronously; the FSM is back in PRIO_VGA after release.
